i2c_bmp180_target: RTL and testbench
====================================

# i2c_bmp180_target

I2C target (responder) that emulates the register map of a BMP180 pressure sensor on the same two-wire bus the `I2C_MASTER`/`BMP180` initiator drives. It lets the controller be exercised on-board or in simulation without a physical sensor. The block decodes START/STOP, matches its 7-bit address and maintains a register pointer. It answers reads from a small register file and reports control writes to the surrounding logic, which supplies fresh measurement words.

## Interface
Parameters:
- `DEV_ADDR`, 7'h77 — 7-bit bus address.
- `CHIP_ID`, 8'h55 — value returned from register 0xD0.

Ports:
- `clk` in 1 — system clock; must be at least 16× the SCL frequency.
- `reset` in 1 — **one clock; reset is asynchronous and active-low.**
- `scl` inout 1 — bus clock; never driven, always high-Z (no clock stretching).
- `sda` inout 1 — bus data, open-drain; drives 0 or high-Z only.
- `meas_data` in 24 — new measurement {MSB, LSB, XLSB} for 0xF6/0xF7/0xF8.
- `meas_valid` in 1 — one-cycle strobe; captures `meas_data`.
- `ctrl_meas` out 8 — current contents of register 0xF4; reset value 8'h00.
- `ctrl_strobe` out 1 — one-cycle pulse after each bus write to 0xF4; reset value 0.
- `soft_reset` out 1 — one-cycle pulse when 8'hB6 is written to 0xE0; reset value 0.
- `busy` out 1 — high from an address-matched START until STOP; reset value 0.

## Operation
- Register map:
  - 0xD0 — read-only, `CHIP_ID`.
  - 0xF4 — read/write.
  - 0xE0 — write-only; reads 0x00.
  - 0xF6–0xF8 — read-only measurement bytes.
  - All other addresses read 0x00 and ignore writes.
- States:
  - IDLE.
  - ADDR: shift 8 bits, MSB first.
  - ADDR_ACK.
  - PTR: first written byte.
  - PTR_ACK.
  - WDATA.
  - WDATA_ACK.
  - RDATA.
  - RACK: sample the master's ACK.
  - IGNORE.
- Transitions:
  - START from any state → ADDR, with the bit counter cleared.
  - In ADDR, address mismatch → IGNORE. IGNORE holds `sda` released until START or STOP.
  - Match with R/W=0 → ADDR_ACK → PTR. The first byte loads the pointer, then PTR_ACK → WDATA. Every WDATA byte writes register[ptr], pointer increments, then WDATA_ACK.
  - Match with R/W=1 → ADDR_ACK → RDATA. The target drives register[ptr] MSB first, pointer increments after each byte, then RACK.
  - In RACK, master ACK → RDATA with the next byte. Master NACK → IGNORE.
  - STOP from any state → IDLE with `sda` released.
- Pointer:
  - 8-bit; wraps 0xFF → 0x00.
  - Retained across repeated START (write-pointer-then-read works) and across STOP.
  - Reset value 0x00.
- Measurement coherence:
  - `meas_valid` while `busy`=0 updates 0xF6–0xF8 on the next clock.
  - `meas_valid` while `busy`=1 is held in a pending buffer and applied on the clock after STOP. A later strobe overwrites the pending value.
- Reset asserted mid-transaction: `sda` is released immediately (asynchronously), the FSM returns to IDLE, and all registers take their reset values.

## Timing
- SCL/SDA pass through a 2-flop synchronizer. Edge and START/STOP detection add 1 cycle, giving 3 `clk` cycles of latency from pin to decision.
- START is SDA falling while SCL is high. STOP is SDA rising while SCL is high.
- Data bits are sampled on the synchronized SCL rising edge.
- `sda` changes only in the `clk` cycle after a synchronized SCL falling edge. It is never changed while SCL is high.
- ACK: `sda` is pulled low from the falling edge after bit 8 until the next falling edge.
- `ctrl_strobe` and `soft_reset` assert one cycle after the SCL rising edge that samples bit 0 (LSB) of the data byte.
- `busy` rises the cycle the address matches and falls the cycle STOP is detected.

## Configuration
- `I2C_BMP180_TARGET_FILTER_EN` defined: each synchronized line passes through a 3-sample majority filter. This adds 2 cycles of latency and rejects pulses of 1 `clk` cycle. The minimum `clk` becomes 20× SCL.
- Undefined: no filter; the latency in Timing applies unchanged.

## Structure
- Shared package `i2c_bmp180_pkg`:
  - FSM state enum.
  - Register address constants (0xD0, 0xE0, 0xF4, 0xF6–0xF8).
  - `SOFT_RESET_KEY` = 8'hB6.
- One sub-module, `i2c_line_sync`, instantiated once per line. It contains the synchronizer, the optional majority filter and rise/fall edge outputs.
- Everything else lives in the top level.

## Test plan
- Write 0x77<<1|0, pointer 0xD0; repeated START, 0xEF; read one byte with NACK → 0x55 returned, both ACKs driven, `busy` low after STOP.
- Write pointer 0xF4 with data 0x2E → `ctrl_meas`=0x2E and one `ctrl_strobe` pulse; a later read of 0xF4 returns 0x2E.
- `meas_valid` with 0x5A3C80 while idle; burst-read 3 bytes from 0xF6 (ACK, ACK, NACK) → 0x5A, 0x3C, 0x80.
- During that burst, strobe 0x111111 after the first byte → the remaining bytes still return 0x3C, 0x80; a read after STOP returns 0x11, 0x11, 0x11.
- Address 0x76 → no ACK, `sda` never driven, `busy` stays 0; write 0xB6 to 0xE0 at 0x77 → one `soft_reset` pulse.
- Assert `reset` while driving a read bit of 0 → `sda` high-Z in the same cycle, `ctrl_meas`=0x00, pointer 0x00.

Source files
------------

// File: rtl/i2c_bmp180_pkg.sv
// Shared types and constants for the BMP180 register-map I2C target.
// Used by i2c_line_sync and i2c_bmp180_target.
package i2c_bmp180_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RACK,
    ST_IGNORE
  } state_e;

  localparam logic [7:0] REG_CHIP_ID    = 8'hD0;
  localparam logic [7:0] REG_SOFT_RESET = 8'hE0;
  localparam logic [7:0] REG_CTRL_MEAS  = 8'hF4;
  localparam logic [7:0] REG_OUT_MSB    = 8'hF6;
  localparam logic [7:0] REG_OUT_LSB    = 8'hF7;
  localparam logic [7:0] REG_OUT_XLSB   = 8'hF8;
  localparam logic [7:0] SOFT_RESET_KEY = 8'hB6;

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizer for one bus line with level and edge outputs.
// Define I2C_BMP180_TARGET_FILTER_EN to add a 3-sample majority glitch filter.
module i2c_line_sync (
  input  logic clk,
  input  logic rst_ni,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [1:0] sync_q;
  logic       filt;
  logic       prev_q;

  // Idle bus is high, so reset to 1 to avoid a spurious edge on release.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) sync_q <= 2'b11;
    else         sync_q <= {sync_q[0], line_i};
  end

`ifdef I2C_BMP180_TARGET_FILTER_EN
  logic [1:0] hist_q;
  logic       maj_q;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      hist_q <= 2'b11;
      maj_q  <= 1'b1;
    end else begin
      hist_q <= {hist_q[0], sync_q[1]};
      maj_q  <= (sync_q[1] & hist_q[0]) | (sync_q[1] & hist_q[1]) | (hist_q[0] & hist_q[1]);
    end
  end

  assign filt = maj_q;
`else
  assign filt = sync_q[1];
`endif

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) prev_q <= 1'b1;
    else         prev_q <= filt;
  end

  assign level_o = filt;
  assign rise_o  = filt & ~prev_q;
  assign fall_o  = ~filt & prev_q;

endmodule

// File: rtl/i2c_bmp180_target.sv
// I2C target emulating the BMP180 register map (chip id, ctrl_meas, soft reset, result bytes).
// Optional line glitch filter: define I2C_BMP180_TARGET_FILTER_EN.
module i2c_bmp180_target
  import i2c_bmp180_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h77,
  parameter logic [7:0] CHIP_ID  = 8'h55
) (
  input  logic        clk,
  input  logic        reset,
  inout  wire         scl,
  inout  wire         sda,
  input  logic [23:0] meas_data,
  input  logic        meas_valid,
  output logic [7:0]  ctrl_meas,
  output logic        ctrl_strobe,
  output logic        soft_reset,
  output logic        busy
);

  logic [1:0] pin_w, lvl_w, rise_w, fall_w;

  assign pin_w = {sda, scl};

  for (genvar gi = 0; gi < 2; gi++) begin : g_sync
    i2c_line_sync u_sync (
      .clk     (clk),
      .rst_ni  (reset),
      .line_i  (pin_w[gi]),
      .level_o (lvl_w[gi]),
      .rise_o  (rise_w[gi]),
      .fall_o  (fall_w[gi])
    );
  end

  logic scl_lvl, scl_rise, scl_fall, sda_lvl, start_det, stop_det;

  assign scl_lvl   = lvl_w[0];
  assign scl_rise  = rise_w[0];
  assign scl_fall  = fall_w[0];
  assign sda_lvl   = lvl_w[1];
  assign start_det = scl_lvl & fall_w[1];
  assign stop_det  = scl_lvl & rise_w[1];

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  ptr_q, ptr_d;
  logic        rw_q, rw_d;
  logic        oe_q, oe_d;
  logic        busy_q, busy_d;
  logic [7:0]  ctrl_meas_q, ctrl_meas_d;
  logic        ctrl_strobe_q, ctrl_strobe_d;
  logic        soft_reset_q, soft_reset_d;
  logic [23:0] meas_q, meas_d;
  logic [23:0] pend_q, pend_d;
  logic        pend_vld_q, pend_vld_d;
  logic [7:0]  byte_in;
  logic [7:0]  rd_byte;

  assign byte_in = {shift_q[6:0], sda_lvl};

  always_comb begin
    rd_byte = 8'h00;
    case (ptr_q)
      REG_CHIP_ID:  rd_byte = CHIP_ID;
      REG_CTRL_MEAS: rd_byte = ctrl_meas_q;
      REG_OUT_MSB:  rd_byte = meas_q[23:16];
      REG_OUT_LSB:  rd_byte = meas_q[15:8];
      REG_OUT_XLSB: rd_byte = meas_q[7:0];
      default:      rd_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 4'd0;
      shift_q       <= 8'h00;
      ptr_q         <= 8'h00;
      rw_q          <= 1'b0;
      oe_q          <= 1'b0;
      busy_q        <= 1'b0;
      ctrl_meas_q   <= 8'h00;
      ctrl_strobe_q <= 1'b0;
      soft_reset_q  <= 1'b0;
      meas_q        <= 24'h0;
      pend_q        <= 24'h0;
      pend_vld_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shift_q       <= shift_d;
      ptr_q         <= ptr_d;
      rw_q          <= rw_d;
      oe_q          <= oe_d;
      busy_q        <= busy_d;
      ctrl_meas_q   <= ctrl_meas_d;
      ctrl_strobe_q <= ctrl_strobe_d;
      soft_reset_q  <= soft_reset_d;
      meas_q        <= meas_d;
      pend_q        <= pend_d;
      pend_vld_q    <= pend_vld_d;
    end
  end

  // In the ACK states cnt_q is a phase flag: 0 = waiting for the fall that
  // starts the ACK, 1 = waiting for the fall that ends it.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shift_d       = shift_q;
    ptr_d         = ptr_q;
    rw_d          = rw_q;
    oe_d          = oe_q;
    busy_d        = busy_q;
    ctrl_meas_d   = ctrl_meas_q;
    ctrl_strobe_d = 1'b0;
    soft_reset_d  = 1'b0;

    if (stop_det) begin
      state_d = ST_IDLE;
      cnt_d   = 4'd0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (start_det) begin
      state_d = ST_ADDR;
      cnt_d   = 4'd0;
      oe_d    = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (scl_rise) begin
            shift_d = byte_in;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d = 4'd0;
              if (byte_in[7:1] == DEV_ADDR) begin
                busy_d  = 1'b1;
                rw_d    = byte_in[0];
                state_d = ST_ADDR_ACK;
              end else begin
                state_d = ST_IGNORE;
              end
            end
          end
        end
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            if (cnt_q == 4'd0) begin
              oe_d  = 1'b1;
              cnt_d = 4'd1;
            end else begin
              cnt_d = 4'd0;
              oe_d  = 1'b0;
              if (state_q == ST_ADDR_ACK && rw_q) begin
                state_d = ST_RDATA;
                shift_d = rd_byte;
                oe_d    = ~rd_byte[7];
                ptr_d   = ptr_q + 8'd1;
              end else if (state_q == ST_ADDR_ACK) begin
                state_d = ST_PTR;
              end else begin
                state_d = ST_WDATA;
              end
            end
          end
        end
        ST_PTR: begin
          if (scl_rise) begin
            shift_d = byte_in;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d   = 4'd0;
              ptr_d   = byte_in;
              state_d = ST_PTR_ACK;
            end
          end
        end
        ST_WDATA: begin
          if (scl_rise) begin
            shift_d = byte_in;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d   = 4'd0;
              ptr_d   = ptr_q + 8'd1;
              state_d = ST_WDATA_ACK;
              if (ptr_q == REG_CTRL_MEAS) begin
                ctrl_meas_d   = byte_in;
                ctrl_strobe_d = 1'b1;
              end
              if (ptr_q == REG_SOFT_RESET && byte_in == SOFT_RESET_KEY) soft_reset_d = 1'b1;
            end
          end
        end
        ST_RDATA: begin
          if (scl_fall) begin
            if (cnt_q == 4'd7) begin
              cnt_d   = 4'd0;
              oe_d    = 1'b0;
              state_d = ST_RACK;
            end else begin
              cnt_d   = cnt_q + 4'd1;
              shift_d = {shift_q[6:0], 1'b0};
              oe_d    = ~shift_q[6];
            end
          end
        end
        ST_RACK: begin
          if (cnt_q == 4'd0) begin
            if (scl_rise) begin
              if (sda_lvl) state_d = ST_IGNORE;
              else         cnt_d   = 4'd1;
            end
          end else if (scl_fall) begin
            cnt_d   = 4'd0;
            state_d = ST_RDATA;
            shift_d = rd_byte;
            oe_d    = ~rd_byte[7];
            ptr_d   = ptr_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Result bytes never change under an active transfer; strobes seen while
  // busy are parked and applied once the bus goes idle.
  always_comb begin
    meas_d     = meas_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (meas_valid && busy_q) begin
      pend_d     = meas_data;
      pend_vld_d = 1'b1;
    end else if (meas_valid) begin
      meas_d     = meas_data;
      pend_vld_d = 1'b0;
    end else if (pend_vld_q && !busy_q) begin
      meas_d     = pend_q;
      pend_vld_d = 1'b0;
    end
  end

  assign sda         = oe_q ? 1'b0 : 1'bz;
  assign scl         = 1'bz;
  assign ctrl_meas   = ctrl_meas_q;
  assign ctrl_strobe = ctrl_strobe_q;
  assign soft_reset  = soft_reset_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_i2c_bmp180_target.sv
// Self-checking bench for i2c_bmp180_target: bit-banged I2C master plus a
// transaction-level register-map model.
module tb_i2c_bmp180_target;

  localparam int         Q       = 6;
  localparam logic [6:0] ADDR    = 7'h77;
  localparam logic [7:0] CHIP_ID = 8'h55;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        scl_drv = 1'b1;
  logic        m_sda_low = 1'b0;
  logic [23:0] meas_data = 24'h0;
  logic        meas_valid = 1'b0;
  logic [7:0]  ctrl_meas;
  logic        ctrl_strobe, soft_reset, busy;
  wire         scl, sda;

  always #5 clk = ~clk;

  assign scl = scl_drv ? 1'bz : 1'b0;
  assign sda = m_sda_low ? 1'b0 : 1'bz;
  pullup (scl);
  pullup (sda);

  i2c_bmp180_target dut (
    .clk         (clk),
    .reset       (reset),
    .scl         (scl),
    .sda         (sda),
    .meas_data   (meas_data),
    .meas_valid  (meas_valid),
    .ctrl_meas   (ctrl_meas),
    .ctrl_strobe (ctrl_strobe),
    .soft_reset  (soft_reset),
    .busy        (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model (transaction level)
  logic [7:0]  m_ptr = 8'h00;
  logic [7:0]  m_ctrl = 8'h00;
  logic [23:0] m_meas = 24'h0;
  logic [23:0] m_pend = 24'h0;
  bit          m_pend_v = 1'b0;
  bit          m_busy = 1'b0;
  int          exp_strobe = 0;
  int          exp_soft = 0;
  logic [7:0]  wbuf [0:3];

  int strobe_cnt = 0;
  int soft_cnt = 0;
  bit dut_drove = 1'b0;

  always @(posedge clk) begin
    #2;
    if (ctrl_strobe === 1'b1) strobe_cnt++;
    if (soft_reset === 1'b1) soft_cnt++;
    if (sda === 1'b0 && !m_sda_low) dut_drove = 1'b1;
  end

  function automatic logic [7:0] model_read(input logic [7:0] p);
    case (p)
      8'hD0:   return CHIP_ID;
      8'hF4:   return m_ctrl;
      8'hF6:   return m_meas[23:16];
      8'hF7:   return m_meas[15:8];
      8'hF8:   return m_meas[7:0];
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_write(input logic [7:0] p, input logic [7:0] b);
    if (p == 8'hF4) begin
      m_ctrl = b;
      exp_strobe++;
    end
    if (p == 8'hE0 && b == 8'hB6) exp_soft++;
  endtask

  task automatic model_stop();
    m_busy = 1'b0;
    if (m_pend_v) begin
      m_meas   = m_pend;
      m_pend_v = 1'b0;
    end
  endtask

  task automatic strobe(input logic [23:0] v);
    @(negedge clk);
    meas_data  = v;
    meas_valid = 1'b1;
    @(negedge clk);
    meas_valid = 1'b0;
    if (m_busy) begin
      m_pend   = v;
      m_pend_v = 1'b1;
    end else begin
      m_meas = v;
    end
  endtask

  // Bus primitives
  task automatic qtr();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda_low = 1'b0; qtr();
    scl_drv = 1'b1;   qtr();
    m_sda_low = 1'b1; qtr();
    scl_drv = 1'b0;   qtr();
  endtask

  task automatic bus_stop();
    m_sda_low = 1'b1; qtr();
    scl_drv = 1'b1;   qtr();
    m_sda_low = 1'b0; qtr();
    qtr();
  endtask

  task automatic send_bit(input bit b);
    m_sda_low = !b; qtr();
    scl_drv = 1'b1; qtr();
    qtr();
    scl_drv = 1'b0; qtr();
  endtask

  task automatic recv_bit(output bit b);
    m_sda_low = 1'b0; qtr();
    scl_drv = 1'b1;   qtr();
    b = (sda === 1'b0) ? 1'b0 : 1'b1;
    qtr();
    scl_drv = 1'b0;   qtr();
  endtask

  task automatic send_byte(input logic [7:0] v, output bit acked);
    bit b;
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
    recv_bit(b);
    acked = !b;
  endtask

  task automatic recv_byte(input bit ack, output logic [7:0] v);
    bit b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      v[i] = b;
    end
    send_bit(!ack);
  endtask

  // Transactions
  task automatic write_regs(input logic [7:0] p, input int n);
    bit ack;
    bus_start();
    send_byte({ADDR, 1'b0}, ack);
    n_tests++;
    if (!ack) begin n_fail++; $display("FAIL wr_addr_ack: got nack, expected ack"); end
    m_busy = 1'b1;
    send_byte(p, ack);
    n_tests++;
    if (!ack) begin n_fail++; $display("FAIL wr_ptr_ack: got nack, expected ack (ptr %h)", p); end
    m_ptr = p;
    for (int i = 0; i < n; i++) begin
      send_byte(wbuf[i], ack);
      n_tests++;
      if (!ack) begin n_fail++; $display("FAIL wr_data_ack: got nack, expected ack (ptr %h)", m_ptr); end
      model_write(m_ptr, wbuf[i]);
      m_ptr++;
    end
    bus_stop();
    model_stop();
    $display("[TB] write ptr=%h bytes=%0d", p, n);
  endtask

  task automatic read_regs(input logic [7:0] p, input int n, input bit set_ptr);
    bit ack;
    logic [7:0] v, e;
    bus_start();
    if (set_ptr) begin
      send_byte({ADDR, 1'b0}, ack);
      n_tests++;
      if (!ack) begin n_fail++; $display("FAIL rd_waddr_ack: got nack, expected ack"); end
      m_busy = 1'b1;
      send_byte(p, ack);
      n_tests++;
      if (!ack) begin n_fail++; $display("FAIL rd_ptr_ack: got nack, expected ack"); end
      m_ptr = p;
      bus_start();
    end
    send_byte({ADDR, 1'b1}, ack);
    n_tests++;
    if (!ack) begin n_fail++; $display("FAIL rd_addr_ack: got nack, expected ack"); end
    m_busy = 1'b1;
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_in_txn: got %b, expected 1", busy); end
    for (int i = 0; i < n; i++) begin
      recv_byte(i != n - 1, v);
      e = model_read(m_ptr);
      n_tests++;
      if (v !== e) begin n_fail++; $display("FAIL rdata: ptr %h got %h, expected %h", m_ptr, v, e); end
      m_ptr++;
    end
    bus_stop();
    model_stop();
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_after_stop: got %b, expected 0", busy); end
    $display("[TB] read ptr=%h bytes=%0d set_ptr=%0d", p, n, set_ptr);
  endtask

  // Scenarios
  task automatic test_reset();
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    n_tests++;
    if (ctrl_meas !== 8'h00) begin n_fail++; $display("FAIL reset_ctrl_meas: got %h, expected 00", ctrl_meas); end
    n_tests++;
    if (ctrl_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_ctrl_strobe: got %b, expected 0", ctrl_strobe); end
    n_tests++;
    if (soft_reset !== 1'b0) begin n_fail++; $display("FAIL reset_soft_reset: got %b, expected 0", soft_reset); end
    n_tests++;
    if (sda !== 1'b1) begin n_fail++; $display("FAIL reset_sda: got %b, expected released", sda); end
    $display("[TB] reset state checked");
  endtask

  task automatic test_chip_id();
    read_regs(8'hD0, 1, 1'b1);
  endtask

  task automatic test_ctrl_write();
    int s0;
    s0 = strobe_cnt;
    wbuf[0] = 8'h2E;
    write_regs(8'hF4, 1);
    n_tests++;
    if (ctrl_meas !== m_ctrl) begin n_fail++; $display("FAIL ctrl_meas: got %h, expected %h", ctrl_meas, m_ctrl); end
    n_tests++;
    if (strobe_cnt - s0 !== 1) begin n_fail++; $display("FAIL ctrl_strobe_pulses: got %0d, expected 1", strobe_cnt - s0); end
    read_regs(8'hF4, 1, 1'b1);
  endtask

  task automatic test_random_regs();
    logic [7:0] plist [0:7];
    logic [7:0] p;
    int n;
    plist[0] = 8'hD0; plist[1] = 8'hE0; plist[2] = 8'hF4; plist[3] = 8'hF5;
    plist[4] = 8'hF6; plist[5] = 8'hFE; plist[6] = 8'hFF; plist[7] = 8'hF3;
    for (int it = 0; it < 10; it++) begin
      p = (it < 8) ? plist[it] : 8'($urandom);
      n = $urandom_range(1, 3);
      for (int k = 0; k < 4; k++) wbuf[k] = ($urandom_range(0, 3) == 0) ? 8'hB6 : 8'($urandom);
      write_regs(p, n);
      n_tests++;
      if (ctrl_meas !== m_ctrl) begin n_fail++; $display("FAIL rnd_ctrl_meas: got %h, expected %h", ctrl_meas, m_ctrl); end
      n_tests++;
      if (strobe_cnt !== exp_strobe) begin n_fail++; $display("FAIL rnd_strobe_count: got %0d, expected %0d", strobe_cnt, exp_strobe); end
      n_tests++;
      if (soft_cnt !== exp_soft) begin n_fail++; $display("FAIL rnd_soft_count: got %0d, expected %0d", soft_cnt, exp_soft); end
      read_regs(p, $urandom_range(1, 3), 1'b1);
    end
  endtask

  task automatic test_meas_burst();
    bit ack;
    logic [7:0] v, e;
    logic [23:0] v1, v2;
    for (int it = 0; it < 3; it++) begin
      v1 = (it == 0) ? 24'h5A3C80 : 24'($urandom);
      v2 = (it == 0) ? 24'h111111 : 24'($urandom);
      strobe(v1);
      repeat (2) @(negedge clk);
      bus_start();
      send_byte({ADDR, 1'b0}, ack);
      m_busy = 1'b1;
      send_byte(8'hF6, ack);
      m_ptr = 8'hF6;
      bus_start();
      send_byte({ADDR, 1'b1}, ack);
      n_tests++;
      if (!ack) begin n_fail++; $display("FAIL burst_addr_ack: got nack, expected ack"); end
      for (int i = 0; i < 3; i++) begin
        recv_byte(i != 2, v);
        e = model_read(m_ptr);
        n_tests++;
        if (v !== e) begin n_fail++; $display("FAIL burst_rdata: ptr %h got %h, expected %h", m_ptr, v, e); end
        m_ptr++;
        if (i == 0) begin
          strobe(v2);
          if (it == 2) strobe(~v2);
        end
      end
      bus_stop();
      model_stop();
      $display("[TB] burst read F6 meas=%h pending=%h", v1, m_meas);
      read_regs(8'hF6, 3, 1'b1);
    end
  endtask

  task automatic test_wrong_addr();
    bit ack;
    dut_drove = 1'b0;
    bus_start();
    send_byte({7'h76, 1'b0}, ack);
    n_tests++;
    if (ack) begin n_fail++; $display("FAIL addr76_ack: got ack, expected nack"); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL addr76_busy: got %b, expected 0", busy); end
    send_byte(8'hF4, ack);
    send_byte(8'h99, ack);
    bus_stop();
    n_tests++;
    if (dut_drove) begin n_fail++; $display("FAIL addr76_sda: got driven, expected released"); end
    n_tests++;
    if (ctrl_meas !== m_ctrl) begin n_fail++; $display("FAIL addr76_ctrl: got %h, expected %h", ctrl_meas, m_ctrl); end
    $display("[TB] write to 0x76 ignored");
  endtask

  task automatic test_soft_reset();
    int s0;
    s0 = soft_cnt;
    wbuf[0] = 8'hB6;
    write_regs(8'hE0, 1);
    n_tests++;
    if (soft_cnt - s0 !== 1) begin n_fail++; $display("FAIL soft_reset_pulses: got %0d, expected 1", soft_cnt - s0); end
    s0 = soft_cnt;
    wbuf[0] = 8'hB7;
    write_regs(8'hE0, 1);
    n_tests++;
    if (soft_cnt - s0 !== 0) begin n_fail++; $display("FAIL soft_reset_wrong_key: got %0d, expected 0", soft_cnt - s0); end
    read_regs(8'hE0, 1, 1'b1);
  endtask

  task automatic test_reset_mid();
    bit ack;
    wbuf[0] = 8'hA5;
    write_regs(8'hF4, 1);
    write_regs(8'hCF, 0);
    bus_start();
    send_byte({ADDR, 1'b1}, ack);
    n_tests++;
    if (sda !== 1'b0) begin n_fail++; $display("FAIL mid_read_bit: got %b, expected 0 driven", sda); end
    reset = 1'b0;
    #1;
    n_tests++;
    if (sda !== 1'b1) begin n_fail++; $display("FAIL reset_async_release: got %b, expected released", sda); end
    n_tests++;
    if (ctrl_meas !== 8'h00) begin n_fail++; $display("FAIL reset_mid_ctrl: got %h, expected 00", ctrl_meas); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid_busy: got %b, expected 0", busy); end
    m_ptr = 8'h00; m_ctrl = 8'h00; m_meas = 24'h0; m_pend_v = 1'b0; m_busy = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    qtr();
    scl_drv = 1'b1;
    qtr(); qtr();
    $display("[TB] reset during read");
    read_regs(8'h00, 1, 1'b0);
    read_regs(8'hF4, 1, 1'b1);
    read_regs(8'hF6, 3, 1'b1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    test_reset();
    test_chip_id();
    test_ctrl_write();
    test_random_regs();
    test_meas_burst();
    test_wrong_addr();
    test_soft_reset();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
